// File: rtl/easy_fifo_pkg.sv
// Shared sizing helpers for the sync_fifo read-side drain stage.
package easy_fifo_pkg;

  localparam int unsigned PKT_CNT_W = 32;

  // Lane index width; a single-lane word still needs a 1-bit index.
  function automatic int unsigned lane_idx_w(input int unsigned ratio);
    return (ratio <= 1) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/fifo_axis_drain_if.sv
// FIFO read port, AXI-Stream master port and status outputs of fifo_axis_drain.
interface fifo_axis_drain_if
  import easy_fifo_pkg::*;
#(
  parameter int unsigned OUT_W = 32,
  parameter int unsigned RATIO = 4
);

  localparam int unsigned FIFO_W = RATIO * OUT_W + 1;

  logic [FIFO_W-1:0]    fifo_rd_data;
  logic                 fifo_rd_empty;
  logic                 fifo_rd_en;
  logic [OUT_W-1:0]     m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic                 m_axis_tready;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic                 idle;

  modport master (
    input  fifo_rd_data, fifo_rd_empty, m_axis_tready,
    output fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast, pkt_cnt, idle
  );

  modport slave (
    output fifo_rd_data, fifo_rd_empty, m_axis_tready,
    input  fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast, pkt_cnt, idle
  );

endinterface

// File: rtl/axis_out_reg.sv
// Single-entry registered AXI-Stream output stage with load enable and completed-packet counter.
module axis_out_reg
  import easy_fifo_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [W-1:0]         load_data,
  input  logic                 load_last,
  output logic                 load_ready,
  input  logic                 tready,
  output logic [W-1:0]         tdata,
  output logic                 tvalid,
  output logic                 tlast,
  output logic [PKT_CNT_W-1:0] pkt_cnt
);

  logic [W-1:0]         tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic                 pkt_done;

  assign load_ready = ~tvalid_q | tready;
  assign pkt_done   = tvalid_q & tready & tlast_q;
  assign pkt_cnt_d  = pkt_cnt_q + PKT_CNT_W'(pkt_done);

  // Data and last only change on load, so they hold while stalled.
  always_comb begin
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (load) begin
      tdata_d  = load_data;
      tlast_d  = load_last;
      tvalid_d = 1'b1;
    end else if (tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign tdata   = tdata_q;
  assign tvalid  = tvalid_q;
  assign tlast   = tlast_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: rtl/fifo_axis_drain.sv
// Read-side drain for sync_fifo: pops first-word-fall-through words and emits RATIO narrow
// AXI-Stream beats per word, lane 0 first, with the word's last flag on its final beat.
module fifo_axis_drain
  import easy_fifo_pkg::*;
#(
  parameter int unsigned OUT_W = 32,
  parameter int unsigned RATIO = 4
) (
  input logic              clk,
  input logic              rst_n,
  fifo_axis_drain_if.master bus
);

  localparam int unsigned LIDX_W = lane_idx_w(RATIO);
  localparam int unsigned WORD_W = RATIO * OUT_W;
  localparam logic [LIDX_W-1:0] LastLane = LIDX_W'(RATIO - 1);

  logic [WORD_W-1:0]    wreg_q, wreg_d;
  logic                 wlast_q, wlast_d;
  logic                 wvalid_q, wvalid_d;
  logic [LIDX_W-1:0]    lidx_q, lidx_d;

  logic                 last_lane;
  logic                 out_ready;
  logic                 oload;
  logic                 pop;
  logic [OUT_W-1:0]     lane_data;
  logic [OUT_W-1:0]     tdata;
  logic                 tvalid;
  logic                 tlast;
  logic [PKT_CNT_W-1:0] pkt_cnt;

  assign last_lane = (lidx_q == LastLane);
  assign oload     = wvalid_q & out_ready;
  // Refill in the same cycle the last lane leaves, so word boundaries cost no bubble.
  assign pop       = ~bus.fifo_rd_empty & (~wvalid_q | (oload & last_lane));
  assign lane_data = wreg_q[OUT_W * int'(lidx_q) +: OUT_W];

  always_comb begin
    wreg_d   = wreg_q;
    wlast_d  = wlast_q;
    wvalid_d = wvalid_q;
    lidx_d   = lidx_q;
    if (oload) begin
      if (last_lane) begin
        lidx_d   = '0;
        wvalid_d = 1'b0;
      end else begin
        lidx_d = lidx_q + 1'b1;
      end
    end
    if (pop) begin
      wreg_d   = bus.fifo_rd_data[WORD_W-1:0];
      wlast_d  = bus.fifo_rd_data[WORD_W];
      wvalid_d = 1'b1;
      lidx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wreg_q   <= '0;
      wlast_q  <= 1'b0;
      wvalid_q <= 1'b0;
      lidx_q   <= '0;
    end else begin
      wreg_q   <= wreg_d;
      wlast_q  <= wlast_d;
      wvalid_q <= wvalid_d;
      lidx_q   <= lidx_d;
    end
  end

  axis_out_reg #(
    .W (OUT_W)
  ) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (oload),
    .load_data  (lane_data),
    .load_last  (wlast_q & last_lane),
    .load_ready (out_ready),
    .tready     (bus.m_axis_tready),
    .tdata      (tdata),
    .tvalid     (tvalid),
    .tlast      (tlast),
    .pkt_cnt    (pkt_cnt)
  );

  assign bus.fifo_rd_en    = pop;
  assign bus.m_axis_tdata  = tdata;
  assign bus.m_axis_tvalid = tvalid;
  assign bus.m_axis_tlast  = tlast;
  assign bus.pkt_cnt       = pkt_cnt;
  assign bus.idle          = ~wvalid_q & ~tvalid;

endmodule

// File: tb/tb_fifo_axis_drain.sv
// Directed bench for fifo_axis_drain: RATIO=4 and RATIO=1 instances fed by small FWFT FIFO models.
module tb_fifo_axis_drain;

  localparam int unsigned OUT_W = 32;
  localparam int unsigned W4 = 4 * OUT_W + 1;
  localparam int unsigned W1 = OUT_W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fifo_axis_drain_if #(.OUT_W(OUT_W), .RATIO(4)) bus4 ();
  fifo_axis_drain_if #(.OUT_W(OUT_W), .RATIO(1)) bus1 ();

  fifo_axis_drain #(.OUT_W(OUT_W), .RATIO(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  fifo_axis_drain #(.OUT_W(OUT_W), .RATIO(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FWFT FIFO models: head pointer advances on the DUT's pop strobe.
  logic [W4-1:0] mem4 [256];
  logic [W1-1:0] mem1 [256];
  int wr4 = 0;
  int wr1 = 0;
  int rd4;
  int rd1;

  assign bus4.fifo_rd_data  = mem4[rd4 % 256];
  assign bus4.fifo_rd_empty = (rd4 == wr4);
  assign bus1.fifo_rd_data  = mem1[rd1 % 256];
  assign bus1.fifo_rd_empty = (rd1 == wr1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd4 <= 0;
      rd1 <= 0;
    end else begin
      if (bus4.fifo_rd_en) rd4 <= rd4 + 1;
      if (bus1.fifo_rd_en) rd1 <= rd1 + 1;
    end
  end

  function automatic logic [31:0] beat_val(input int w, input int l);
    return 32'hA000_0000 | 32'(w << 8) | 32'(l);
  endfunction

  function automatic logic [W4-1:0] make4(input int w, input bit last);
    logic [W4-1:0] r;
    r[W4-1] = last;
    for (int l = 0; l < 4; l++) r[l*32 +: 32] = beat_val(w, l);
    return r;
  endfunction

  task automatic push4(input logic [W4-1:0] w);
    mem4[wr4 % 256] = w;
    wr4++;
  endtask

  task automatic push1(input logic [W1-1:0] w);
    mem1[wr1 % 256] = w;
    wr1++;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    bus4.m_axis_tready = 1'b0;
    bus1.m_axis_tready = 1'b0;
    wr4 = 0;
    wr1 = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.m_axis_tready = 1'b0;
    bus1.m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus4.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b want 0", bus4.m_axis_tvalid); end
    checks++; if (bus4.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %0b want 0", bus4.m_axis_tlast); end
    checks++; if (bus4.pkt_cnt !== 32'd0) begin errors++; $display("FAIL reset_pkt_cnt: got %0h want 0", bus4.pkt_cnt); end
    checks++; if (bus4.idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %0b want 1", bus4.idle); end
    checks++; if (bus4.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0b want 0", bus4.fifo_rd_en); end
    checks++; if (bus1.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid_r1: got %0b want 0", bus1.m_axis_tvalid); end
    checks++; if (bus1.idle !== 1'b1) begin errors++; $display("FAIL reset_idle_r1: got %0b want 1", bus1.idle); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    logic [128:0] w;
    logic [31:0] d [8];
    logic l [8];
    int c [8];
    int n;
    int t0;
    logic [31:0] exp_d;
    w = {1'b1, 128'h44444444_33333333_22222222_11111111};
    n = 0;
    reset_all();
    @(posedge clk); #1;
    bus4.m_axis_tready = 1'b1;
    push4(w);
    t0 = cyc;
    #1;
    checks++; if (bus4.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL single_pop: got %0b want 1", bus4.fifo_rd_en); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus4.m_axis_tvalid && bus4.m_axis_tready) begin
        if (n < 8) begin d[n] = bus4.m_axis_tdata; l[n] = bus4.m_axis_tlast; c[n] = cyc; end
        n++;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL single_beats: got %0d want 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      exp_d = w[i*32 +: 32];
      checks++; if (d[i] !== exp_d) begin errors++; $display("FAIL single_data[%0d]: got %h want %h", i, d[i], exp_d); end
      checks++; if (l[i] !== (i == 3)) begin errors++; $display("FAIL single_last[%0d]: got %0b want %0b", i, l[i], i == 3); end
      checks++; if (c[i] != t0 + 2 + i) begin errors++; $display("FAIL single_cycle[%0d]: got %0d want %0d", i, c[i], t0 + 2 + i); end
    end
    checks++; if (bus4.pkt_cnt !== 32'd1) begin errors++; $display("FAIL single_pkt_cnt: got %0d want 1", bus4.pkt_cnt); end
    checks++; if (bus4.idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %0b want 1", bus4.idle); end
  endtask

  task automatic test_stream();
    logic [31:0] d [40];
    logic l [40];
    int c [40];
    int n;
    int t0;
    n = 0;
    reset_all();
    @(posedge clk); #1;
    bus4.m_axis_tready = 1'b1;
    for (int k = 0; k < 8; k++) push4(make4(k, (k == 2) || (k == 7)));
    t0 = cyc;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus4.m_axis_tvalid && bus4.m_axis_tready) begin
        if (n < 40) begin d[n] = bus4.m_axis_tdata; l[n] = bus4.m_axis_tlast; c[n] = cyc; end
        n++;
      end
    end
    checks++; if (n != 32) begin errors++; $display("FAIL stream_beats: got %0d want 32", n); end
    for (int i = 0; i < 32 && i < n; i++) begin
      checks++; if (d[i] !== beat_val(i / 4, i % 4)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, d[i], beat_val(i / 4, i % 4)); end
      checks++; if (l[i] !== ((i == 11) || (i == 31))) begin errors++; $display("FAIL stream_last[%0d]: got %0b", i, l[i]); end
      checks++; if (c[i] != t0 + 2 + i) begin errors++; $display("FAIL stream_cycle[%0d]: got %0d want %0d", i, c[i], t0 + 2 + i); end
    end
    checks++; if (bus4.pkt_cnt !== 32'd2) begin errors++; $display("FAIL stream_pkt_cnt: got %0d want 2", bus4.pkt_cnt); end
  endtask

  task automatic test_backpressure();
    int pushed;
    int got;
    int word;
    int lane;
    logic prev_stall;
    logic [31:0] prev_d;
    logic prev_l;
    logic [31:0] exp_d;
    logic exp_l;
    pushed = 0;
    got = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    reset_all();
    for (int k = 0; k < 4000 && got < 400; k++) begin
      @(posedge clk); #1;
      bus4.m_axis_tready = ($urandom_range(0, 1) == 1);
      if (pushed < 100 && $urandom_range(0, 1) == 1) begin
        push4(make4(pushed + 16, (pushed % 3) == 2));
        pushed++;
      end
      @(negedge clk);
      checks++;
      if (bus4.fifo_rd_en && bus4.fifo_rd_empty) begin errors++; $display("FAIL bp_pop_empty: rd_en=1 with empty=1 at cycle %0d", cyc); end
      if (prev_stall) begin
        checks++;
        if (bus4.m_axis_tvalid !== 1'b1 || bus4.m_axis_tdata !== prev_d || bus4.m_axis_tlast !== prev_l) begin
          errors++;
          $display("FAIL bp_stall: got v=%0b d=%h l=%0b want v=1 d=%h l=%0b", bus4.m_axis_tvalid, bus4.m_axis_tdata, bus4.m_axis_tlast, prev_d, prev_l);
        end
      end
      if (bus4.m_axis_tvalid && bus4.m_axis_tready) begin
        word = got / 4;
        lane = got % 4;
        exp_d = beat_val(word + 16, lane);
        exp_l = (lane == 3) && ((word % 3) == 2);
        checks++;
        if (bus4.m_axis_tdata !== exp_d || bus4.m_axis_tlast !== exp_l) begin
          errors++;
          $display("FAIL bp_beat[%0d]: got d=%h l=%0b want d=%h l=%0b", got, bus4.m_axis_tdata, bus4.m_axis_tlast, exp_d, exp_l);
        end
        got++;
      end
      prev_stall = bus4.m_axis_tvalid && !bus4.m_axis_tready;
      prev_d = bus4.m_axis_tdata;
      prev_l = bus4.m_axis_tlast;
    end
    @(posedge clk); #1;
    checks++; if (got != 400) begin errors++; $display("FAIL bp_beats: got %0d want 400", got); end
    checks++; if (bus4.pkt_cnt !== 32'd33) begin errors++; $display("FAIL bp_pkt_cnt: got %0d want 33", bus4.pkt_cnt); end
  endtask

  task automatic test_ratio1();
    int pops;
    int n;
    int t0;
    pops = 0;
    n = 0;
    reset_all();
    @(posedge clk); #1;
    bus1.m_axis_tready = 1'b1;
    for (int k = 0; k < 10; k++) push1({1'b1, 32'(k)});
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.fifo_rd_en) begin
        checks++; if (cyc != t0 + pops) begin errors++; $display("FAIL r1_pop_cycle[%0d]: got %0d want %0d", pops, cyc, t0 + pops); end
        pops++;
      end
      if (bus1.m_axis_tvalid && bus1.m_axis_tready) begin
        checks++;
        if (bus1.m_axis_tdata !== 32'(n) || bus1.m_axis_tlast !== 1'b1 || cyc != t0 + 2 + n) begin
          errors++;
          $display("FAIL r1_beat[%0d]: got d=%0d l=%0b cyc=%0d want d=%0d l=1 cyc=%0d", n, bus1.m_axis_tdata, bus1.m_axis_tlast, cyc, n, t0 + 2 + n);
        end
        n++;
      end
    end
    checks++; if (pops != 10) begin errors++; $display("FAIL r1_pops: got %0d want 10", pops); end
    checks++; if (n != 10) begin errors++; $display("FAIL r1_beats: got %0d want 10", n); end
    checks++; if (bus1.pkt_cnt !== 32'd10) begin errors++; $display("FAIL r1_pkt_cnt: got %0d want 10", bus1.pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    n = 0;
    seen = 0;
    reset_all();
    @(posedge clk); #1;
    bus4.m_axis_tready = 1'b1;
    push4(make4(40, 1'b1));
    push4(make4(41, 1'b1));
    for (int i = 0; i < 30 && n < 6; i++) begin
      @(negedge clk);
      if (bus4.m_axis_tvalid && bus4.m_axis_tready) n++;
    end
    checks++; if (n != 6) begin errors++; $display("FAIL mid_reach: got %0d beats want 6", n); end
    @(posedge clk); #2;
    checks++; if (bus4.m_axis_tdata !== beat_val(41, 2)) begin errors++; $display("FAIL mid_pre_data: got %h want %h", bus4.m_axis_tdata, beat_val(41, 2)); end
    checks++; if (bus4.pkt_cnt !== 32'd1) begin errors++; $display("FAIL mid_pre_pkt_cnt: got %0d want 1", bus4.pkt_cnt); end
    rst_n = 1'b0;
    wr4 = 0;
    #1;
    checks++; if (bus4.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %0b want 0", bus4.m_axis_tvalid); end
    checks++; if (bus4.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL mid_tlast: got %0b want 0", bus4.m_axis_tlast); end
    checks++; if (bus4.pkt_cnt !== 32'd0) begin errors++; $display("FAIL mid_pkt_cnt: got %0d want 0", bus4.pkt_cnt); end
    checks++; if (bus4.idle !== 1'b1) begin errors++; $display("FAIL mid_idle: got %0b want 1", bus4.idle); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus4.m_axis_tvalid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_after_beats: got %0d want 0", seen); end
    checks++; if (bus4.idle !== 1'b1) begin errors++; $display("FAIL mid_after_idle: got %0b want 1", bus4.idle); end
  endtask

  task automatic test_wrap();
    bit seen;
    seen = 1'b0;
    reset_all();
    force dut.u_out.pkt_cnt_d = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.u_out.pkt_cnt_d;
    checks++; if (bus4.pkt_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preset: got %h want ffffffff", bus4.pkt_cnt); end
    bus4.m_axis_tready = 1'b1;
    push4(make4(50, 1'b1));
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus4.m_axis_tvalid && bus4.m_axis_tready && bus4.m_axis_tlast) seen = 1'b1;
    end
    @(posedge clk); #1;
    checks++; if (!seen) begin errors++; $display("FAIL wrap_tlast: no tlast beat within 20 cycles"); end
    checks++; if (bus4.pkt_cnt !== 32'd0) begin errors++; $display("FAIL wrap_pkt_cnt: got %h want 0", bus4.pkt_cnt); end
  endtask

  initial begin
    bus4.m_axis_tready = 1'b0;
    bus1.m_axis_tready = 1'b0;
    test_reset();
    test_single_word();
    test_stream();
    test_backpressure();
    test_ratio1();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
